// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Sequencer states, register-zero constant and per-stage control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MD_BUSY,
        MEM_WAIT
    } hz_state_t;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic hold;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/md_countdown.sv
// Mul/div occupancy countdown: load, decrement or freeze.
// o_done flags the final EX cycle of the operation (count of one).
module md_countdown #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load has priority; without load or dec the count is frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use, taken branches, mul/div occupancy and memory waits.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = 8,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  i_id_rs,
    input  logic [REG_W-1:0]  i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic [REG_W-1:0]  i_ex_rd,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_branch_taken,
    input  logic              i_ex_md_start,
    input  logic              i_mem_req,
    input  logic              i_mem_ready,
    output logic              o_pc_hold,
    output logic              o_ifid_hold,
    output logic              o_ifid_flush,
    output logic              o_idex_hold,
    output logic              o_idex_flush,
    output logic              o_exmem_hold,
    output logic              o_exmem_flush,
    output logic              o_memwb_flush,
    output logic              o_md_busy,
    output logic [PERF_W-1:0] o_stall_count
);

    localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LATENCY - 1);

    hz_state_t         r_state;
    hz_state_t         r_ret_state;
    logic [PERF_W-1:0] r_stall_count;

    hz_state_t   w_next;
    stage_ctrl_t w_ifid;
    stage_ctrl_t w_idex;
    stage_ctrl_t w_exmem;
    logic        w_pc_hold;
    logic        w_memwb_flush;
    logic        w_md_busy;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_done;
    logic        w_ret_load;
    logic        w_mem_wait;
    logic        w_load_use;
    logic        w_md_occ;
    logic [CNT_W-1:0] w_md_cnt;

    md_countdown #(
        .W(CNT_W)
    ) u_md_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (MD_INIT),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_md_cnt),
        .o_done     (w_cnt_done)
    );

    assign w_mem_wait = i_mem_req & ~i_mem_ready;
    assign w_load_use = i_ex_mem_read
                      & (i_ex_rd != REG_W'(REG_ZERO))
                      & ((i_ex_rd == i_id_rs)
                      | (i_id_uses_rt & (i_ex_rd == i_id_rt)));
    assign w_md_occ   = (r_state == MD_BUSY)
                      | ((r_state == MEM_WAIT) & (r_ret_state == MD_BUSY));

    // Same-cycle control decode from state and hazard inputs.
    always_comb begin
        w_next        = r_state;
        w_ifid        = '0;
        w_idex        = '0;
        w_exmem       = '0;
        w_pc_hold     = 1'b0;
        w_memwb_flush = 1'b0;
        w_md_busy     = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        w_ret_load    = 1'b0;
        if (reset) begin
            w_ifid.flush  = 1'b1;
            w_idex.flush  = 1'b1;
            w_exmem.flush = 1'b1;
            w_memwb_flush = 1'b1;
            w_next        = RUN;
        end else if (w_mem_wait) begin
            w_pc_hold     = 1'b1;
            w_ifid.hold   = 1'b1;
            w_idex.hold   = 1'b1;
            w_exmem.hold  = 1'b1;
            w_memwb_flush = 1'b1;
            w_md_busy     = w_md_occ;
            w_next        = MEM_WAIT;
            w_ret_load    = (r_state != MEM_WAIT);
        end else begin
            unique case (r_state)
                RUN: begin
                    if (i_ex_branch_taken) begin
                        w_ifid.flush = 1'b1;
                        w_idex.flush = 1'b1;
                    end else if (i_ex_md_start) begin
                        w_pc_hold     = 1'b1;
                        w_ifid.hold   = 1'b1;
                        w_idex.hold   = 1'b1;
                        w_exmem.flush = 1'b1;
                        w_md_busy     = 1'b1;
                        w_cnt_load    = 1'b1;
                        w_next        = MD_BUSY;
                    end else if (w_load_use) begin
                        w_pc_hold    = 1'b1;
                        w_ifid.hold  = 1'b1;
                        w_idex.flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_done) begin
                        w_next = RUN;
                    end else begin
                        w_pc_hold     = 1'b1;
                        w_ifid.hold   = 1'b1;
                        w_idex.hold   = 1'b1;
                        w_exmem.flush = 1'b1;
                        w_md_busy     = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    w_md_busy = (r_ret_state == MD_BUSY);
                    w_next    = r_ret_state;
                end
                default: begin
                    w_next = RUN;
                end
            endcase
        end
    end

    // State and return-state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
        end else begin
            r_state <= w_next;
            if (w_ret_load) begin
                r_ret_state <= r_state;
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_pc_hold && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + PERF_W'(1);
        end
    end

    assign o_pc_hold     = w_pc_hold;
    assign o_ifid_hold   = w_ifid.hold;
    assign o_ifid_flush  = w_ifid.flush;
    assign o_idex_hold   = w_idex.hold;
    assign o_idex_flush  = w_idex.flush;
    assign o_exmem_hold  = w_exmem.hold;
    assign o_exmem_flush = w_exmem.flush;
    assign o_memwb_flush = w_memwb_flush;
    assign o_md_busy     = w_md_busy;
    assign o_stall_count = r_stall_count;

endmodule
